// File: rtl/uart_tetris_pkg.sv
// Shared definitions for the UART command receiver: state encoding,
// command bytes, button codes and the default bit period.
package uart_tetris_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;

  // state     | meaning
  // ST_IDLE   | line idle, watching for a falling edge
  // ST_START  | half-bit wait, then confirm start bit is still low
  // ST_DATA   | one full bit period per data bit, LSB first
  // ST_STOP   | one full bit period, then check stop bit
  // ST_BREAK  | stop bit was low, wait for the line to return high
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam logic [7:0] CMD_RIGHT_LC = 8'h64;  // 'd'
  localparam logic [7:0] CMD_RIGHT_UC = 8'h44;  // 'D'
  localparam logic [7:0] CMD_LEFT_LC  = 8'h61;  // 'a'
  localparam logic [7:0] CMD_LEFT_UC  = 8'h41;  // 'A'
  localparam logic [7:0] CMD_ROT_F_LC = 8'h77;  // 'w'
  localparam logic [7:0] CMD_ROT_F_UC = 8'h57;  // 'W'
  localparam logic [7:0] CMD_ROT_B_LC = 8'h73;  // 's'
  localparam logic [7:0] CMD_ROT_B_UC = 8'h53;  // 'S'

  localparam logic [3:0] BTN_NONE  = 4'b0000;
  localparam logic [3:0] BTN_RIGHT = 4'b0001;
  localparam logic [3:0] BTN_LEFT  = 4'b1000;
  localparam logic [3:0] BTN_ROT_F = 4'b0100;
  localparam logic [3:0] BTN_ROT_B = 4'b0010;

  // Map a received byte to its one-hot button code; unknown bytes give none.
  function automatic logic [3:0] decode_cmd(input logic [7:0] b);
    logic [3:0] btn;
    btn = BTN_NONE;
    case (b)
      CMD_RIGHT_LC, CMD_RIGHT_UC: btn = BTN_RIGHT;
      CMD_LEFT_LC,  CMD_LEFT_UC:  btn = BTN_LEFT;
      CMD_ROT_F_LC, CMD_ROT_F_UC: btn = BTN_ROT_F;
      CMD_ROT_B_LC, CMD_ROT_B_UC: btn = BTN_ROT_B;
      default:                    btn = BTN_NONE;
    endcase
    return btn;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level 8N1 receiver: input synchronizer, framing FSM, baud and bit
// counters. valid/ferr are single-cycle strobes in the stop-sample cycle;
// data holds the assembled byte and is meaningful while valid is high.
module uart_rx_core
  import uart_tetris_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);

  localparam int             CW      = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0]  FULL_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1;
  logic          sync2;
  logic          rx_prev;
  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  logic fall;
  logic half_tc;
  logic full_tc;

  // Two-flop synchronizer plus one delayed copy for edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign fall    = rx_prev & ~sync2;
  assign half_tc = (cnt == HALF_TC);
  assign full_tc = (cnt == FULL_TC);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (fall) state_nxt = ST_START;
      ST_START: if (half_tc) state_nxt = sync2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (full_tc && (idx == 3'd7)) state_nxt = ST_STOP;
      ST_STOP:  if (full_tc) state_nxt = sync2 ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (sync2) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output strobes, decided in the stop-sample cycle.
  always_comb begin
    valid = 1'b0;
    ferr  = 1'b0;
    if (state == ST_STOP && full_tc) begin
      valid = sync2;
      ferr  = ~sync2;
    end
  end

  // Baud counter: held at 0 while waiting, reloaded on any state change and
  // at every data-bit expiry, so it never runs past its terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state || state == ST_IDLE || state == ST_BREAK) begin
      cnt <= '0;
    end else if (state == ST_DATA && full_tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Bit index and data assembly, LSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else if (state == ST_IDLE && fall) begin
      idx <= 3'd0;
    end else if (state == ST_DATA && full_tc) begin
      shreg[idx] <= sync2;
      idx        <= idx + 3'd1;
    end
  end

  assign data = shreg;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver top: bit-level receiver plus a registered
// byte-to-button decode feeding the LED/tetris stage.
module uart_cmd_rx
  import uart_tetris_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] button,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  logic [7:0] core_data;
  logic       core_valid;
  logic       core_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .data (core_data),
    .valid(core_valid),
    .ferr (core_ferr)
  );

  // Register the decoded command and strobes so all outputs line up one cycle
  // after the stop-bit sample; rx_byte only moves on a good frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      button     <= BTN_NONE;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= core_valid;
      frame_err  <= core_ferr;
      button     <= core_valid ? decode_cmd(core_data) : BTN_NONE;
      if (core_valid) rx_byte <= core_data;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit.
module tb_uart_cmd_rx;
  import uart_tetris_pkg::*;

  localparam int CPB = 16;
  localparam int LAT = 155;  // start-bit drive edge to byte_valid edge

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [3:0] button;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         vq_cyc[$];
  logic [3:0] vq_btn[$];
  logic [7:0] vq_byte[$];
  int         ferr_cnt = 0;
  int         bad_btn  = 0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .button    (button),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record output events away from the active edge.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_btn.push_back(button);
      vq_byte.push_back(rx_byte);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (!rst && byte_valid !== 1'b1 && button !== 4'b0000) bad_btn++;
    if ($countones(button) > 1) bad_btn++;
  end

  task automatic clear_log();
    vq_cyc.delete();
    vq_btn.delete();
    vq_byte.delete();
    ferr_cnt = 0;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Caller must be aligned just after an edge; leaves alignment intact.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (button !== 4'b0000) begin n_fail++; $display("FAIL reset_button got %b want 0000", button); end
    n_tests++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte got %h want 00", rx_byte); end
    n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_single();
    int t0;
    clear_log();
    align();
    send_frame(8'h64, 1'b1, t0);
    repeat (20) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", vq_cyc.size()); end
    if (vq_cyc.size() >= 1) begin
      n_tests++; if (vq_btn[0] !== 4'b0001) begin n_fail++; $display("FAIL single_button got %b want 0001", vq_btn[0]); end
      n_tests++; if (vq_byte[0] !== 8'h64) begin n_fail++; $display("FAIL single_byte got %h want 64", vq_byte[0]); end
      n_tests++; if (vq_cyc[0] != t0 + LAT) begin n_fail++; $display("FAIL single_latency got %0d want %0d", vq_cyc[0] - t0, LAT); end
    end
    n_tests++; if (rx_byte !== 8'h64) begin n_fail++; $display("FAIL single_hold got %h want 64", rx_byte); end
    n_tests++; if (byte_valid !== 1'b0 || button !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_end got valid=%b btn=%b want 0/0000", byte_valid, button); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    logic [3:0] btns  [3];
    int t0, tx;
    bytes = '{8'h41, 8'h77, 8'h53};
    btns  = '{4'b1000, 4'b0100, 4'b0010};
    clear_log();
    align();
    send_frame(bytes[0], 1'b1, t0);
    send_frame(bytes[1], 1'b1, tx);
    send_frame(bytes[2], 1'b1, tx);
    repeat (20) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", vq_cyc.size()); end
    if (vq_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (vq_btn[i] !== btns[i]) begin n_fail++; $display("FAIL b2b_button%0d got %b want %b", i, vq_btn[i], btns[i]); end
        n_tests++; if (vq_byte[i] !== bytes[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, vq_byte[i], bytes[i]); end
        n_tests++; if (vq_cyc[i] != t0 + LAT + 160 * i) begin n_fail++; $display("FAIL b2b_time%0d got %0d want %0d", i, vq_cyc[i] - t0, LAT + 160 * i); end
      end
    end
  endtask

  task automatic test_other_byte();
    int t0;
    clear_log();
    align();
    send_frame(8'h7A, 1'b1, t0);
    repeat (20) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 1) begin n_fail++; $display("FAIL other_count got %0d want 1", vq_cyc.size()); end
    if (vq_cyc.size() >= 1) begin
      n_tests++; if (vq_btn[0] !== 4'b0000) begin n_fail++; $display("FAIL other_button got %b want 0000", vq_btn[0]); end
      n_tests++; if (vq_byte[0] !== 8'h7A) begin n_fail++; $display("FAIL other_byte got %h want 7a", vq_byte[0]); end
    end
  endtask

  task automatic test_glitch();
    clear_log();
    align();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 0 || ferr_cnt != 0) begin n_fail++; $display("FAIL glitch_quiet got valids=%0d ferrs=%0d want 0/0", vq_cyc.size(), ferr_cnt); end
    n_tests++; if (dut.u_core.state !== ST_IDLE) begin n_fail++; $display("FAIL glitch_idle got state %0d want %0d", dut.u_core.state, ST_IDLE); end
    n_tests++; if (rx_byte !== 8'h7A) begin n_fail++; $display("FAIL glitch_hold got %h want 7a", rx_byte); end
  endtask

  task automatic test_frame_err();
    int t0;
    clear_log();
    align();
    send_frame(8'h64, 1'b0, t0);
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    n_tests++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL ferr_count got %0d want 1", ferr_cnt); end
    n_tests++; if (vq_cyc.size() != 0) begin n_fail++; $display("FAIL ferr_no_valid got %0d want 0", vq_cyc.size()); end
    n_tests++; if (rx_byte !== 8'h7A) begin n_fail++; $display("FAIL ferr_hold got %h want 7a", rx_byte); end
    clear_log();
    send_frame(8'h64, 1'b1, t0);
    repeat (20) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 1) begin n_fail++; $display("FAIL ferr_recover_count got %0d want 1", vq_cyc.size()); end
    if (vq_cyc.size() >= 1) begin
      n_tests++; if (vq_btn[0] !== 4'b0001) begin n_fail++; $display("FAIL ferr_recover_button got %b want 0001", vq_btn[0]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int t0;
    b = 8'h73;
    clear_log();
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (button !== 4'b0000 || byte_valid !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got btn=%b v=%b fe=%b want 0000/0/0", button, byte_valid, frame_err); end
    n_tests++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_rx_byte got %h want 00", rx_byte); end
    rst = 1'b0;
    rx  = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 0 || ferr_cnt != 0) begin n_fail++; $display("FAIL midrst_no_pulse got valids=%0d ferrs=%0d want 0/0", vq_cyc.size(), ferr_cnt); end
    send_frame(8'h73, 1'b1, t0);
    repeat (20) @(posedge clk);
    #1;
    n_tests++; if (vq_cyc.size() != 1) begin n_fail++; $display("FAIL midrst_count got %0d want 1", vq_cyc.size()); end
    if (vq_cyc.size() >= 1) begin
      n_tests++; if (vq_btn[0] !== 4'b0010) begin n_fail++; $display("FAIL midrst_button got %b want 0010", vq_btn[0]); end
      n_tests++; if (vq_byte[0] !== 8'h73) begin n_fail++; $display("FAIL midrst_byte got %h want 73", vq_byte[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_other_byte();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    n_tests++; if (bad_btn != 0) begin n_fail++; $display("FAIL button_invariant got %0d bad cycles want 0", bad_btn); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
